// File: rtl/op_sequencer_if.sv
// -----------------------------------------------------------------------------
// op_sequencer_if
// Command channel into the op_sequencer: one command per valid/ready handshake.
//   cmd_valid     master -> slave  command present
//   cmd_ready     slave  -> master sequencer can accept a command
//   cmd_op        master -> slave  00 MWRITE, 01 LOAD, 10 STORE, 11 ALU
//   cmd_a/b/d     master -> slave  source A, source B, destination selects
//   cmd_alu_ctrl  master -> slave  ALU function code (ALU only)
//   cmd_data      master -> slave  write word (MWRITE only)
// -----------------------------------------------------------------------------
interface op_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_a;
   logic [ADDR_W-1:0] cmd_b;
   logic [ADDR_W-1:0] cmd_d;
   logic [3:0]        cmd_alu_ctrl;
   logic [DATA_W-1:0] cmd_data;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, cmd_alu_ctrl, cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, cmd_alu_ctrl, cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
// Accepts one command at a time and expands it into per-cycle strobes for the
// datapath (memory external/register ports, register file, ALU). Latches the
// ALU zero flag on ALU commands and counts completed commands.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_if (slave)      command handshake and fields
//   alu_zero            zero output from the ALU, sampled at the end of ALU P2
//   data_in, read_address, write_address, wenable, renable
//                       memory external port
//   read_address_reg, write_address_reg, wenable_reg, renable_reg
//                       memory register-side port
//   reg1, reg2, address_mem, address_alu, address_to_mem,
//   wenable_mem, renable_mem, wenable_alu, renable_alu
//                       register-file selects and strobes
//   alu_ctrl            ALU function
//   busy, done          command in progress / one-cycle completion pulse
//   zero_flag, ops_done latched ALU zero / completed-command count (wraps)
// -----------------------------------------------------------------------------
module op_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   op_sequencer_if.slave     cmd_if,
   input  logic              alu_zero,
   output logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] read_address,
   output logic [ADDR_W-1:0] write_address,
   output logic              wenable,
   output logic              renable,
   output logic [ADDR_W-1:0] read_address_reg,
   output logic [ADDR_W-1:0] write_address_reg,
   output logic              wenable_reg,
   output logic              renable_reg,
   output logic [ADDR_W-1:0] reg1,
   output logic [ADDR_W-1:0] reg2,
   output logic [ADDR_W-1:0] address_mem,
   output logic [ADDR_W-1:0] address_alu,
   output logic [ADDR_W-1:0] address_to_mem,
   output logic              wenable_mem,
   output logic              renable_mem,
   output logic              wenable_alu,
   output logic              renable_alu,
   output logic [3:0]        alu_ctrl,
   output logic              busy,
   output logic              done,
   output logic              zero_flag,
   output logic [CNT_W-1:0]  ops_done
);

   typedef enum logic [1:0] {S_IDLE, S_P1, S_P2} state_t;
   typedef enum logic [1:0] {OP_MWRITE = 2'b00, OP_LOAD = 2'b01,
                             OP_STORE  = 2'b10, OP_ALU  = 2'b11} op_t;

   // Every output is a register; the whole set lives in one struct so the
   // output logic can start from "hold everything" and override per phase.
   typedef struct packed {
      logic [DATA_W-1:0] data_in;
      logic [ADDR_W-1:0] read_address;
      logic [ADDR_W-1:0] write_address;
      logic [ADDR_W-1:0] read_address_reg;
      logic [ADDR_W-1:0] write_address_reg;
      logic [ADDR_W-1:0] reg1;
      logic [ADDR_W-1:0] reg2;
      logic [ADDR_W-1:0] address_mem;
      logic [ADDR_W-1:0] address_alu;
      logic [ADDR_W-1:0] address_to_mem;
      logic              wenable;
      logic              renable;
      logic              wenable_reg;
      logic              renable_reg;
      logic              wenable_mem;
      logic              renable_mem;
      logic              wenable_alu;
      logic              renable_alu;
      logic [3:0]        alu_ctrl;
      logic              cmd_ready;
      logic              busy;
      logic              done;
      logic              zero_flag;
      logic [CNT_W-1:0]  ops_done;
   } out_t;

   state_t            r_state;
   state_t            w_next_state;
   op_t               r_op;
   logic [ADDR_W-1:0] r_d;
   out_t              r_out;
   out_t              w_out;
   logic              w_accept;

   // cmd_ready is registered and only high in IDLE, so a held cmd_valid can
   // only be taken once per IDLE cycle.
   assign w_accept = cmd_if.cmd_valid && r_out.cmd_ready;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of process ordering.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned
      // (an unassigned path would infer a latch).
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_P1;
         S_P1:    w_next_state = (r_op == OP_MWRITE) ? S_IDLE : S_P2;
         S_P2:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic: computes the value every output register takes at the next
   // edge. P1 values come straight from the command fields at accept time, so
   // a, b, alu_ctrl and data are effectively captured in the output registers
   // themselves; only op and d need a separate copy for the P2 phase.
   always_comb begin
      w_out             = r_out;
      w_out.wenable     = 1'b0;
      w_out.renable     = 1'b0;
      w_out.wenable_reg = 1'b0;
      w_out.renable_reg = 1'b0;
      w_out.wenable_mem = 1'b0;
      w_out.renable_mem = 1'b0;
      w_out.wenable_alu = 1'b0;
      w_out.renable_alu = 1'b0;
      w_out.done        = 1'b0;
      w_out.cmd_ready   = (w_next_state == S_IDLE);
      w_out.busy        = (w_next_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (op_t'(cmd_if.cmd_op))
                  OP_MWRITE: begin
                     w_out.wenable       = 1'b1;
                     w_out.write_address = cmd_if.cmd_d;
                     w_out.data_in       = cmd_if.cmd_data;
                  end
                  OP_LOAD: begin
                     w_out.renable_reg      = 1'b1;
                     w_out.read_address_reg = cmd_if.cmd_a;
                  end
                  OP_STORE: begin
                     w_out.renable_mem    = 1'b1;
                     w_out.address_to_mem = cmd_if.cmd_a;
                  end
                  OP_ALU: begin
                     w_out.renable_alu = 1'b1;
                     w_out.reg1        = cmd_if.cmd_a;
                     w_out.reg2        = cmd_if.cmd_b;
                     w_out.alu_ctrl    = cmd_if.cmd_alu_ctrl;
                  end
               endcase
            end
         end
         S_P1: begin
            case (r_op)
               OP_LOAD: begin
                  w_out.wenable_mem = 1'b1;
                  w_out.address_mem = r_d;
               end
               OP_STORE: begin
                  w_out.wenable_reg       = 1'b1;
                  w_out.write_address_reg = r_d;
               end
               OP_ALU: begin
                  // reg1/reg2/alu_ctrl keep their P1 values through the hold
                  w_out.wenable_alu = 1'b1;
                  w_out.address_alu = r_d;
               end
               default: ; // MWRITE has no second phase
            endcase
         end
         S_P2: begin
            if (r_op == OP_ALU) w_out.zero_flag = alu_zero;
         end
         default: ;
      endcase

      // Completion lands in the IDLE cycle that follows the last phase.
      if (r_state != S_IDLE && w_next_state == S_IDLE) begin
         w_out.done     = 1'b1;
         w_out.ops_done = r_out.ops_done + CNT_W'(1);
      end
   end

   // Output and command-capture registers
   always_ff @(posedge clk) begin
      // NOTE: synchronous reset clears every output register, including the
      // held addresses and data, so the datapath sees a clean zero state.
      if (rst) begin
         r_out <= '0;
         r_op  <= OP_MWRITE;
         r_d   <= '0;
      end else begin
         r_out <= w_out;
         if (w_accept) begin
            r_op <= op_t'(cmd_if.cmd_op);
            r_d  <= cmd_if.cmd_d;
         end
      end
   end

   assign cmd_if.cmd_ready  = r_out.cmd_ready;
   assign data_in           = r_out.data_in;
   assign read_address      = r_out.read_address;
   assign write_address     = r_out.write_address;
   assign wenable           = r_out.wenable;
   assign renable           = r_out.renable;
   assign read_address_reg  = r_out.read_address_reg;
   assign write_address_reg = r_out.write_address_reg;
   assign wenable_reg       = r_out.wenable_reg;
   assign renable_reg       = r_out.renable_reg;
   assign reg1              = r_out.reg1;
   assign reg2              = r_out.reg2;
   assign address_mem       = r_out.address_mem;
   assign address_alu       = r_out.address_alu;
   assign address_to_mem    = r_out.address_to_mem;
   assign wenable_mem       = r_out.wenable_mem;
   assign renable_mem       = r_out.renable_mem;
   assign wenable_alu       = r_out.wenable_alu;
   assign renable_alu       = r_out.renable_alu;
   assign alu_ctrl          = r_out.alu_ctrl;
   assign busy              = r_out.busy;
   assign done              = r_out.done;
   assign zero_flag         = r_out.zero_flag;
   assign ops_done          = r_out.ops_done;

endmodule

// File: tb/tb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_op_sequencer
// Scoreboard bench for op_sequencer. The driver issues commands and, from the
// command semantics alone, predicts the full output snapshot for every cycle in
// which a strobe or done pulse must appear; the monitor compares each cycle.
// The counter is shrunk to 8 bits so the wrap can be reached quickly.
// -----------------------------------------------------------------------------
module tb_op_sequencer;

   localparam int A_W = 8;
   localparam int D_W = 32;
   localparam int C_W = 8;

   // strobe vector order: {wenable, renable, wenable_reg, renable_reg,
   //                       wenable_mem, renable_mem, wenable_alu, renable_alu}
   localparam logic [7:0] ST_WEN     = 8'h80;
   localparam logic [7:0] ST_WEN_REG = 8'h20;
   localparam logic [7:0] ST_REN_REG = 8'h10;
   localparam logic [7:0] ST_WEN_MEM = 8'h08;
   localparam logic [7:0] ST_REN_MEM = 8'h04;
   localparam logic [7:0] ST_WEN_ALU = 8'h02;
   localparam logic [7:0] ST_REN_ALU = 8'h01;

   typedef struct packed {
      logic [7:0]     strb;
      logic [A_W-1:0] write_address;
      logic [A_W-1:0] read_address;
      logic [A_W-1:0] write_address_reg;
      logic [A_W-1:0] read_address_reg;
      logic [A_W-1:0] reg1;
      logic [A_W-1:0] reg2;
      logic [A_W-1:0] address_mem;
      logic [A_W-1:0] address_alu;
      logic [A_W-1:0] address_to_mem;
      logic [D_W-1:0] data_in;
      logic [3:0]     alu_ctrl;
      logic           busy;
      logic           done;
      logic           ready;
      logic           zero;
      logic [C_W-1:0] ops;
   } snap_t;

   localparam int CW = $bits(snap_t);

   typedef struct {
      int    cyc;
      snap_t s;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic alu_zero;
   logic [D_W-1:0] data_in;
   logic [A_W-1:0] read_address, write_address, read_address_reg, write_address_reg;
   logic [A_W-1:0] reg1, reg2, address_mem, address_alu, address_to_mem;
   logic wenable, renable, wenable_reg, renable_reg;
   logic wenable_mem, renable_mem, wenable_alu, renable_alu;
   logic [3:0] alu_ctrl;
   logic busy, done, zero_flag;
   logic [C_W-1:0] ops_done;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        cyc      = 0;
   bit        mon_en   = 1'b0;
   logic [255:0] zero_tab;
   exp_t      exp_q[$];
   snap_t     mdl;
   int        m_ops    = 0;
   logic      m_zero   = 1'b0;

   op_sequencer_if #(.ADDR_W(A_W), .DATA_W(D_W)) sif ();

   op_sequencer #(.ADDR_W(A_W), .DATA_W(D_W), .CNT_W(C_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_if            (sif),
      .alu_zero          (alu_zero),
      .data_in           (data_in),
      .read_address      (read_address),
      .write_address     (write_address),
      .wenable           (wenable),
      .renable           (renable),
      .read_address_reg  (read_address_reg),
      .write_address_reg (write_address_reg),
      .wenable_reg       (wenable_reg),
      .renable_reg       (renable_reg),
      .reg1              (reg1),
      .reg2              (reg2),
      .address_mem       (address_mem),
      .address_alu       (address_alu),
      .address_to_mem    (address_to_mem),
      .wenable_mem       (wenable_mem),
      .renable_mem       (renable_mem),
      .wenable_alu       (wenable_alu),
      .renable_alu       (renable_alu),
      .alu_ctrl          (alu_ctrl),
      .busy              (busy),
      .done              (done),
      .zero_flag         (zero_flag),
      .ops_done          (ops_done)
   );

   always #5 clk = ~clk;

   // cyc counts rising edges; alu_zero during cycle k is zero_tab[k mod 256],
   // so the driver knows in advance what the ALU reports in any future cycle.
   always @(posedge clk) cyc <= cyc + 1;
   assign alu_zero = zero_tab[cyc[7:0]];

   function automatic snap_t sample();
      snap_t s;
      s.strb              = {wenable, renable, wenable_reg, renable_reg,
                             wenable_mem, renable_mem, wenable_alu, renable_alu};
      s.write_address     = write_address;
      s.read_address      = read_address;
      s.write_address_reg = write_address_reg;
      s.read_address_reg  = read_address_reg;
      s.reg1              = reg1;
      s.reg2              = reg2;
      s.address_mem       = address_mem;
      s.address_alu       = address_alu;
      s.address_to_mem    = address_to_mem;
      s.data_in           = data_in;
      s.alu_ctrl          = alu_ctrl;
      s.busy              = busy;
      s.done              = done;
      s.ready             = sif.cmd_ready;
      s.zero              = zero_flag;
      s.ops               = ops_done;
      return s;
   endfunction

   task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic push(input int c, input snap_t s);
      exp_t e;
      e.cyc = c;
      e.s   = s;
      exp_q.push_back(e);
   endtask

   // Reference model: what the outputs must look like in each cycle of a
   // command accepted at the edge that ends cycle c.
   task automatic predict(input logic [1:0] op, input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                          input logic [A_W-1:0] d, input logic [3:0] ctrl,
                          input logic [D_W-1:0] data, input int c);
      snap_t s;
      int    last;
      s      = mdl;
      s.strb = '0;
      s.busy = 1'b1;
      s.ready = 1'b0;
      s.done = 1'b0;
      s.ops  = C_W'(m_ops);
      s.zero = m_zero;
      case (op)
         2'b00: begin
            s.strb = ST_WEN; s.write_address = d; s.data_in = data;
            push(c + 1, s); last = c + 1;
         end
         2'b01: begin
            s.strb = ST_REN_REG; s.read_address_reg = a; push(c + 1, s);
            s.strb = ST_WEN_MEM; s.address_mem = d;      push(c + 2, s);
            last = c + 2;
         end
         2'b10: begin
            s.strb = ST_REN_MEM; s.address_to_mem = a;    push(c + 1, s);
            s.strb = ST_WEN_REG; s.write_address_reg = d; push(c + 2, s);
            last = c + 2;
         end
         default: begin
            s.strb = ST_REN_ALU; s.reg1 = a; s.reg2 = b; s.alu_ctrl = ctrl; push(c + 1, s);
            s.strb = ST_WEN_ALU; s.address_alu = d;                          push(c + 2, s);
            last   = c + 2;
            m_zero = zero_tab[8'((c + 2) % 256)];
         end
      endcase
      m_ops   = (m_ops + 1) % (1 << C_W);
      s.strb  = '0;
      s.busy  = 1'b0;
      s.ready = 1'b1;
      s.done  = 1'b1;
      s.ops   = C_W'(m_ops);
      s.zero  = m_zero;
      push(last + 1, s);
      mdl = s;
   endtask

   // Called at a falling edge; returns at the falling edge of the P1 cycle with
   // cmd_valid still high (caller drops it or presents the next command).
   task automatic issue(input logic [1:0] op, input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                        input logic [A_W-1:0] d, input logic [3:0] ctrl, input logic [D_W-1:0] data);
      int waited = 0;
      sif.cmd_op = op; sif.cmd_a = a; sif.cmd_b = b; sif.cmd_d = d;
      sif.cmd_alu_ctrl = ctrl; sif.cmd_data = data; sif.cmd_valid = 1'b1;
      while (!sif.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!sif.cmd_ready) begin
         check("accept_timeout", CW'(sif.cmd_ready), CW'(1));
         sif.cmd_valid = 1'b0;
         return;
      end
      predict(op, a, b, d, ctrl, data, cyc);
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      sif.cmd_valid    = 1'b0;
      sif.cmd_op       = 2'($urandom);
      sif.cmd_a        = A_W'($urandom);
      sif.cmd_d        = A_W'($urandom);
      sif.cmd_data     = $urandom;
      repeat (k) @(negedge clk);
   endtask

   task automatic do_reset();
      sif.cmd_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      mdl = '0; m_ops = 0; m_zero = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", CW'(sample()), CW'(0));
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", CW'(sif.cmd_ready), CW'(1));
   endtask

   // Monitor: one comparison per cycle, either against the scheduled snapshot
   // or against "no strobe and no done" when nothing is due.
   always @(negedge clk) begin : monitor
      snap_t act;
      exp_t  e;
      if (mon_en) begin
         act = sample();
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL missed_output cyc=%0d: got nothing, expected %h", e.cyc, e.s);
         end
         n_checks++;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            if (act !== e.s) begin
               n_fail++;
               $display("FAIL scoreboard cyc=%0d: got %h expected %h", cyc, act, e.s);
            end
         end else if (act.strb != '0 || act.done) begin
            n_fail++;
            $display("FAIL unexpected_output cyc=%0d: got %h expected no strobe/done", cyc, act);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      for (int i = 0; i < 256; i++) zero_tab[i] = 1'($urandom);
      sif.cmd_valid = 1'b0; sif.cmd_op = '0; sif.cmd_a = '0; sif.cmd_b = '0;
      sif.cmd_d = '0; sif.cmd_alu_ctrl = '0; sif.cmd_data = '0;

      // while rst is held the sequencer must not offer ready
      @(negedge clk);
      check("ready_in_reset", CW'(sif.cmd_ready), CW'(0));
      do_reset();
      mon_en = 1'b1;

      // directed commands
      issue(2'b00, 8'h00, 8'h00, 8'h05, 4'h0, 32'hDEADBEEF); idle(2);
      issue(2'b01, 8'h05, 8'h00, 8'h03, 4'h0, 32'h0);       idle(3);
      zero_tab = '1;
      issue(2'b11, 8'h01, 8'h02, 8'h07, 4'h2, 32'h0);       idle(3);
      issue(2'b10, 8'h03, 8'h00, 8'h04, 4'h0, 32'h0);       idle(3);
      check("zero_after_store", CW'(zero_flag), CW'(1));
      zero_tab = '0;
      issue(2'b11, 8'h09, 8'h0A, 8'h0B, 4'h5, 32'h0);       idle(3);
      check("zero_cleared_by_alu", CW'(zero_flag), CW'(0));
      for (int i = 0; i < 256; i++) zero_tab[i] = 1'($urandom);

      // back-to-back LOAD then STORE with cmd_valid held
      base = m_ops;
      issue(2'b01, 8'h11, 8'h00, 8'h22, 4'h0, 32'h0);
      issue(2'b10, 8'h33, 8'h00, 8'h44, 4'h0, 32'h0);
      idle(4);
      check("b2b_count", CW'(ops_done), CW'((base + 2) % 256));

      // randomized traffic, mixing held-valid and gapped commands
      for (int n = 0; n < 150; n++) begin
         issue(2'($urandom), A_W'($urandom), A_W'($urandom), A_W'($urandom),
               4'($urandom), $urandom);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(4);

      // reset during P1 of a LOAD aborts it
      do_reset();
      issue(2'b01, 8'h05, 8'h00, 8'h03, 4'h0, 32'h0);
      #1;
      exp_q.delete();
      mdl = '0; m_ops = 0; m_zero = 1'b0;
      rst = 1'b1;
      sif.cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_outputs", CW'(sample()), CW'(0));
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", CW'(sif.cmd_ready), CW'(1));
      idle(3);
      check("abort_count", CW'(ops_done), CW'(0));

      // reset wins over a simultaneous command
      sif.cmd_op = 2'b00; sif.cmd_d = 8'h66; sif.cmd_data = 32'h12345678;
      sif.cmd_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("rst_vs_accept", CW'(sample()), CW'(0));
      sif.cmd_valid = 1'b0; rst = 1'b0;
      idle(3);

      // counter wrap: fill to all-ones, then one more
      do_reset();
      for (int n = 0; n < (1 << C_W) - 1; n++)
         issue(2'b00, 8'h00, 8'h00, A_W'($urandom), 4'h0, $urandom);
      idle(3);
      check("count_full", CW'(ops_done), CW'((1 << C_W) - 1));
      issue(2'b00, 8'h00, 8'h00, 8'h5A, 4'h0, 32'hCAFEF00D);
      sif.cmd_valid = 1'b0;
      @(negedge clk);
      check("wrap_done", CW'(done), CW'(1));
      check("wrap_count", CW'(ops_done), CW'(0));
      idle(5);

      check("queue_drained", CW'(exp_q.size()), CW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Command sequencer that sits directly upstream of the datapath top level (memory, registers, security, ALU). It accepts one command at a time over a valid/ready handshake and breaks it into cycle-by-cycle enable, address and ALU-control strobes for the datapath. The supported commands are external memory write, load (memory to register), store (register to memory) and ALU operation. It latches the ALU zero flag and counts completed commands.

## Interface
Parameters:
- ADDR_W, 8, width of every address/register-select field
- DATA_W, 32, data word width
- CNT_W, 16, width of completed-command counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 MWRITE, 01 LOAD, 10 STORE, 11 ALU
- cmd_a, cmd_b, cmd_d  in  ADDR_W  source A, source B, destination
- cmd_alu_ctrl  in  4  ALU function code (ALU op only)
- cmd_data  in  DATA_W  write word (MWRITE only)
- alu_zero  in  1  zero output from ALU
- data_in  out  DATA_W  memory external write data
- read_address, write_address  out  ADDR_W  memory external port addresses
- wenable, renable  out  1  memory external port strobes
- read_address_reg, write_address_reg  out  ADDR_W  memory register-side addresses
- wenable_reg, renable_reg  out  1  memory register-side strobes
- reg1, reg2, address_mem, address_alu, address_to_mem  out  ADDR_W  register-file selects
- wenable_mem, renable_mem, wenable_alu, renable_alu  out  1  register-file strobes
- alu_ctrl  out  4  ALU function
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- zero_flag  out  1  latched ALU zero
- ops_done  out  CNT_W  completed-command count

## Operation
- All outputs are registered. FSM states: IDLE, P1, P2.
- cmd_ready=1 only in IDLE. On cmd_valid && cmd_ready, capture op, a, b, d, alu_ctrl and data, then go to P1.
- Phase strobes. Exactly one of the eight strobes is high per phase; all others are 0.
  - MWRITE: P1: wenable=1, write_address=d, data_in=data. Then IDLE; no P2.
  - LOAD: P1: renable_reg=1, read_address_reg=a. P2: wenable_mem=1, address_mem=d.
  - STORE: P1: renable_mem=1, address_to_mem=a. P2: wenable_reg=1, write_address_reg=d.
  - ALU: P1: renable_alu=1, reg1=a, reg2=b, alu_ctrl=ctrl. P2: wenable_alu=1, address_alu=d, and reg1/reg2/alu_ctrl held. zero_flag <= alu_zero at the end of P2.
- Address, data and alu_ctrl outputs hold their last driven value between commands. Only the strobes return to 0.
- After the last phase the FSM returns to IDLE. done=1 and ops_done increments by 1 in that same IDLE cycle.
- ops_done wraps from 2^CNT_W-1 to 0.
- busy = (state != IDLE).
- zero_flag changes only on ALU commands.

## Timing
- A command accepted at edge N produces P1 in cycle N+1.
  - Two-phase ops: P2 in N+2; done and cmd_ready high in N+3.
  - MWRITE: done and cmd_ready high in N+2.
- Back-to-back: a command presented in the done cycle is accepted at that edge. Its P1 follows with no bubble.
- cmd_* inputs are ignored while cmd_ready=0. A held cmd_valid is not consumed twice.
- Reset values:
  - state = IDLE
  - all strobes 0, all addresses 0, data_in 0, alu_ctrl 0
  - busy 0, done 0, zero_flag 0, ops_done 0
  - cmd_ready 0 while rst is high, 1 in the first cycle after release.
- Reset mid-command aborts it. No strobe is asserted in the cycle after the reset edge, no done pulse, no count.
- rst overrides acceptance when asserted in the same cycle as cmd_valid.

## Test plan
- Reset then MWRITE (d=0x05, data=0xDEADBEEF) -> wenable=1 with write_address=0x05 and data_in=0xDEADBEEF in the cycle after accept; done 1 cycle later; ops_done=1.
- LOAD a=0x05, d=0x03 -> renable_reg=1 with read_address_reg=0x05 at N+1; wenable_mem=1 with address_mem=0x03 at N+2; done at N+3; no other strobe high.
- ALU a=1, b=2, ctrl=0x2, with alu_zero=1 during P2 -> renable_alu at N+1, wenable_alu with address_alu=d at N+2, zero_flag=1 from N+3. Following STORE leaves zero_flag=1.
- Back-to-back LOAD then STORE with cmd_valid held continuously -> STORE P1 in the cycle after LOAD done; each command executed exactly once; ops_done=2.
- rst asserted during P1 of a LOAD -> no wenable_mem ever; done stays 0; ops_done=0; cmd_ready=1 the cycle after rst falls.
- Preload ops_done to 0xFFFF via 65535 MWRITEs, then one more -> ops_done=0x0000 and done pulses.
